tank_life_manager: RTL and testbench

- Parametrised collision and life manager for N_PLAYERS player tanks and N_ENEMIES enemy tanks.
- Resolves bullet-vs-tank, bullet-vs-bullet and bullet-vs-terrain hits.
- Runs one life/respawn FSM per tank and reports per-side game-over.
- Sits between the sprite-overlap detectors (pixel-level box/bullet flags) and the game controller/renderer.

---
 rtl/tank_pkg.sv | 17 +
 rtl/tank_life_fsm.sv | 129 ++++++++++++
 rtl/tank_life_manager.sv | 110 +++++++++++
 tb/tb_tank_life_manager.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared types and default timing constants for the tank life manager.
package tank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIVE = 2'd1,
        DEAD  = 2'd2,
        OUT   = 2'd3
    } life_state_e;

    localparam int LIVES_W_DEF       = 4;
    localparam int CNT_W_DEF         = 32;
    localparam int REVIVE_P_DEF      = 1000000;
    localparam int REVIVE_E_DEF      = 5000000;
    localparam int SHIELD_CYCLES_DEF = 500000;

endpackage

// File: rtl/tank_life_fsm.sv
// Life/respawn FSM for one tank: state, respawn timer, spare-lives counter, revive pulse.
// Optional spawn shield after respawn when SPAWN_SHIELD_EN is defined.
import tank_pkg::*;

module tank_life_fsm #(
    parameter int REVIVE  = REVIVE_P_DEF,
    parameter int LIVES_W = LIVES_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
`ifdef SPAWN_SHIELD_EN
    ,
    parameter int SHIELD_CYCLES = SHIELD_CYCLES_DEF
`endif
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic [LIVES_W-1:0] lives_i,
    input  logic               hit_i,
    output logic               die_o,
    output logic               revive_o,
    output logic               out_o,
    output logic [LIVES_W-1:0] lives_left_o
`ifdef SPAWN_SHIELD_EN
    ,
    output logic               shield_o
`endif
);

    life_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_timer, w_timer_nxt;
    logic [LIVES_W-1:0] r_lives, w_lives_nxt;
    logic               r_revive, w_revive_nxt;
    logic               r_die;
`ifdef SPAWN_SHIELD_EN
    logic               r_shield, w_shield_nxt;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= IDLE;
            r_timer  <= '0;
            r_lives  <= '0;
            r_revive <= 1'b0;
            r_die    <= 1'b0;
`ifdef SPAWN_SHIELD_EN
            r_shield <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_lives  <= w_lives_nxt;
            r_revive <= w_revive_nxt;
            r_die    <= (w_state_nxt == DEAD) || (w_state_nxt == OUT);
`ifdef SPAWN_SHIELD_EN
            r_shield <= w_shield_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_lives_nxt  = r_lives;
        w_revive_nxt = 1'b0;
`ifdef SPAWN_SHIELD_EN
        w_shield_nxt = r_shield;
`endif
        if (load_i) begin
            w_timer_nxt = '0;
`ifdef SPAWN_SHIELD_EN
            w_shield_nxt = 1'b0;
`endif
            if (lives_i == '0) begin
                w_state_nxt = OUT;
                w_lives_nxt = '0;
            end else begin
                w_state_nxt = ALIVE;
                w_lives_nxt = lives_i - LIVES_W'(1);
            end
        end else begin
            case (r_state)
                ALIVE: begin
`ifdef SPAWN_SHIELD_EN
                    // Timer is free while alive, so it doubles as the shield counter
                    if (r_shield) begin
                        if (r_timer == CNT_W'(SHIELD_CYCLES - 1)) begin
                            w_shield_nxt = 1'b0;
                            w_timer_nxt  = '0;
                        end else begin
                            w_timer_nxt = r_timer + CNT_W'(1);
                        end
                    end else
`endif
                    if (hit_i) begin
                        w_state_nxt = DEAD;
                        w_timer_nxt = '0;
                    end
                end
                DEAD: begin
                    if (r_timer == CNT_W'(REVIVE - 1)) begin
                        w_timer_nxt = '0;
                        if (r_lives != '0) begin
                            w_lives_nxt  = r_lives - LIVES_W'(1);
                            w_state_nxt  = ALIVE;
                            w_revive_nxt = 1'b1;
`ifdef SPAWN_SHIELD_EN
                            w_shield_nxt = 1'b1;
`endif
                        end else begin
                            w_state_nxt = OUT;
                        end
                    end else begin
                        w_timer_nxt = r_timer + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign die_o        = r_die;
    assign revive_o     = r_revive;
    assign out_o        = (r_state == OUT);
    assign lives_left_o = r_lives;
`ifdef SPAWN_SHIELD_EN
    assign shield_o     = r_shield;
`endif

endmodule

// File: rtl/tank_life_manager.sv
// Collision resolution plus per-tank life FSMs and per-side game-over flags.
// Optional spawn shield (shield_o) enabled by defining SPAWN_SHIELD_EN.
import tank_pkg::*;

module tank_life_manager #(
    parameter int N_PLAYERS     = 2,
    parameter int N_ENEMIES     = 4,
    parameter int LIVES_W       = LIVES_W_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int REVIVE_P      = REVIVE_P_DEF,
    parameter int REVIVE_E      = REVIVE_E_DEF,
    parameter int SHIELD_CYCLES = SHIELD_CYCLES_DEF
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   load_i,
    input  logic [(N_PLAYERS+N_ENEMIES)*LIVES_W-1:0] lives_i,
    input  logic [N_PLAYERS+N_ENEMIES-1:0]         box_i,
    input  logic [N_PLAYERS+N_ENEMIES-1:0]         bullet_i,
    input  logic                                   hard_block_i,
    input  logic                                   destroyable_block_i,
    input  logic                                   eagle_block_i,
    output logic [N_PLAYERS+N_ENEMIES-1:0]         bullet_explode_o,
    output logic                                   collide_wall_o,
    output logic                                   collide_eagle_o,
    output logic [N_PLAYERS+N_ENEMIES-1:0]         die_o,
    output logic [N_PLAYERS+N_ENEMIES-1:0]         revive_o,
    output logic [(N_PLAYERS+N_ENEMIES)*LIVES_W-1:0] lives_left_o,
    output logic                                   players_out_o,
    output logic                                   enemies_out_o
`ifdef SPAWN_SHIELD_EN
    ,
    output logic [N_PLAYERS+N_ENEMIES-1:0]         shield_o
`endif
);

    localparam int N_TANKS = N_PLAYERS + N_ENEMIES;

    if (REVIVE_P < 2 || REVIVE_E < 2 || SHIELD_CYCLES < 1) begin : g_bad_param
        $error("tank_life_manager: REVIVE_P/REVIVE_E must be >= 2 and SHIELD_CYCLES >= 1");
    end

    logic               w_pb, w_eb, w_anybox;
    logic [N_TANKS-1:0] w_hit;
    logic [N_TANKS-1:0] w_out;
    logic               r_players_out, r_enemies_out;

    assign w_pb     = |bullet_i[N_PLAYERS-1:0];
    assign w_eb     = |bullet_i[N_TANKS-1:N_PLAYERS];
    assign w_anybox = |box_i;

    // Each side is only threatened by the other side's bullets
    always_comb begin
        bullet_explode_o = '0;
        w_hit            = '0;
        for (int k = 0; k < N_TANKS; k++) begin
            if (k < N_PLAYERS) begin
                bullet_explode_o[k] = bullet_i[k] & (hard_block_i | w_anybox | w_eb);
                w_hit[k]            = box_i[k] & w_eb;
            end else begin
                bullet_explode_o[k] = bullet_i[k] & (hard_block_i | w_anybox | w_pb);
                w_hit[k]            = box_i[k] & w_pb;
            end
        end
    end

    assign collide_wall_o  = destroyable_block_i & (|bullet_i);
    assign collide_eagle_o = eagle_block_i & (|bullet_i);

    for (genvar g = 0; g < N_TANKS; g++) begin : g_tank
        localparam int REV = (g < N_PLAYERS) ? REVIVE_P : REVIVE_E;
        tank_life_fsm #(
            .REVIVE  (REV),
            .LIVES_W (LIVES_W),
            .CNT_W   (CNT_W)
`ifdef SPAWN_SHIELD_EN
            ,
            .SHIELD_CYCLES (SHIELD_CYCLES)
`endif
        ) u_fsm (
            .clk_i        (clk_i),
            .reset_i      (reset_i),
            .load_i       (load_i),
            .lives_i      (lives_i[g*LIVES_W +: LIVES_W]),
            .hit_i        (w_hit[g]),
            .die_o        (die_o[g]),
            .revive_o     (revive_o[g]),
            .out_o        (w_out[g]),
            .lives_left_o (lives_left_o[g*LIVES_W +: LIVES_W])
`ifdef SPAWN_SHIELD_EN
            ,
            .shield_o     (shield_o[g])
`endif
        );
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_players_out <= 1'b0;
            r_enemies_out <= 1'b0;
        end else begin
            r_players_out <= &w_out[N_PLAYERS-1:0];
            r_enemies_out <= &w_out[N_TANKS-1:N_PLAYERS];
        end
    end

    assign players_out_o = r_players_out;
    assign enemies_out_o = r_enemies_out;

endmodule

// File: tb/tb_tank_life_manager.sv
// Directed bench for tank_life_manager (2 players, 2 enemies, short respawn delays).
module tb_tank_life_manager;

    localparam int NT = 4;
    localparam int LW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             load;
    logic [NT*LW-1:0] lives;
    logic [NT-1:0]    box, bullet;
    logic             hard, brick, eagle;
    logic [NT-1:0]    explode, die, revive;
    logic             wall, eag;
    logic [NT*LW-1:0] lleft;
    logic             pout, eout;
`ifdef SPAWN_SHIELD_EN
    logic [NT-1:0]    shield;
`endif

    int n_vec = 0;
    int n_err = 0;

    tank_life_manager #(
        .N_PLAYERS(2), .N_ENEMIES(2), .LIVES_W(LW), .CNT_W(32),
        .REVIVE_P(8), .REVIVE_E(16), .SHIELD_CYCLES(4)
    ) dut (
        .clk_i(clk), .reset_i(reset), .load_i(load), .lives_i(lives),
        .box_i(box), .bullet_i(bullet), .hard_block_i(hard),
        .destroyable_block_i(brick), .eagle_block_i(eagle),
        .bullet_explode_o(explode), .collide_wall_o(wall), .collide_eagle_o(eag),
        .die_o(die), .revive_o(revive), .lives_left_o(lleft),
        .players_out_o(pout), .enemies_out_o(eout)
`ifdef SPAWN_SHIELD_EN
        , .shield_o(shield)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        load = 1'b0; box = '0; bullet = '0; hard = 1'b0; brick = 1'b0; eagle = 1'b0;
    endtask

    task automatic do_load(input logic [NT*LW-1:0] lv);
        @(negedge clk);
        lives = lv; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; lives = '0; clear_inputs();
        repeat (2) @(negedge clk);
        n_vec++; if (die !== 4'b0) begin n_err++; $display("FAIL reset_die: got %b expected 0000", die); end
        n_vec++; if (revive !== 4'b0) begin n_err++; $display("FAIL reset_revive: got %b expected 0000", revive); end
        n_vec++; if (lleft !== 16'h0) begin n_err++; $display("FAIL reset_lives: got %h expected 0000", lleft); end
        n_vec++; if ({pout, eout} !== 2'b00) begin n_err++; $display("FAIL reset_out: got %b expected 00", {pout, eout}); end
        reset = 1'b0;
    endtask

    task automatic test_load();
        do_load(16'h1233);
        n_vec++; if (lleft !== 16'h0122) begin n_err++; $display("FAIL load_lives: got %h expected 0122", lleft); end
        n_vec++; if (die !== 4'b0) begin n_err++; $display("FAIL load_die: got %b expected 0000", die); end
        n_vec++; if (revive !== 4'b0) begin n_err++; $display("FAIL load_revive: got %b expected 0000", revive); end
    endtask

    task automatic test_hit_revive();
        int dc, rc, ri;
        dc = 0; rc = 0; ri = -1;
        box = 4'b0001; bullet = 4'b0100;
        #1;
        n_vec++; if (explode !== 4'b0100) begin n_err++; $display("FAIL hit_explode: got %b expected 0100", explode); end
        @(negedge clk);
        clear_inputs();
        for (int i = 0; i < 12; i++) begin
            if (die[0]) dc++;
            if (revive[0]) begin rc++; ri = i; end
            @(negedge clk);
        end
        n_vec++; if (dc != 8) begin n_err++; $display("FAIL hit_dead_cycles: got %0d expected 8", dc); end
        n_vec++; if (rc != 1 || ri != 8) begin n_err++; $display("FAIL hit_revive_pulse: got count %0d at %0d expected 1 at 8", rc, ri); end
        n_vec++; if (lleft[3:0] !== 4'd1) begin n_err++; $display("FAIL hit_lives0: got %0d expected 1", lleft[3:0]); end
    endtask

    task automatic test_friendly();
        box = 4'b0010; bullet = 4'b0011;
        #1;
        n_vec++; if (explode !== 4'b0011) begin n_err++; $display("FAIL friendly_on_box_explode: got %b expected 0011", explode); end
        @(negedge clk);
        clear_inputs();
        n_vec++; if (die !== 4'b0) begin n_err++; $display("FAIL friendly_no_kill: got %b expected 0000", die); end
        bullet = 4'b0011;
        #1;
        n_vec++; if (explode !== 4'b0000) begin n_err++; $display("FAIL friendly_bullets_explode: got %b expected 0000", explode); end
        bullet = 4'b1001;
        #1;
        n_vec++; if (explode !== 4'b1001) begin n_err++; $display("FAIL opposing_bullets_explode: got %b expected 1001", explode); end
        bullet = 4'b0001; hard = 1'b1;
        #1;
        n_vec++; if (explode !== 4'b0001) begin n_err++; $display("FAIL hard_block_explode: got %b expected 0001", explode); end
        hard = 1'b0; bullet = 4'b0100; brick = 1'b1; eagle = 1'b1;
        #1;
        n_vec++; if ({wall, eag} !== 2'b11) begin n_err++; $display("FAIL wall_eagle_hit: got %b expected 11", {wall, eag}); end
        bullet = 4'b0000;
        #1;
        n_vec++; if ({wall, eag} !== 2'b00) begin n_err++; $display("FAIL wall_eagle_nobullet: got %b expected 00", {wall, eag}); end
        brick = 1'b0; eagle = 1'b0;
        box = 4'b1000; bullet = 4'b0100;
        @(negedge clk);
        clear_inputs();
        n_vec++; if (die !== 4'b0) begin n_err++; $display("FAIL enemy_friendly_no_kill: got %b expected 0000", die); end
    endtask

    task automatic test_enemy_out();
        int t;
        box = 4'b1000; bullet = 4'b0001;
        @(negedge clk);
        clear_inputs();
        repeat (16) @(negedge clk);
        n_vec++; if (die[3] !== 1'b1 || eout !== 1'b0) begin n_err++; $display("FAIL tank3_out: got die3=%b eout=%b expected 1 0", die[3], eout); end
        box = 4'b0100; bullet = 4'b0010;
        @(negedge clk);
        clear_inputs();
        t = 0;
        while (!revive[2] && t < 40) begin @(negedge clk); t++; end
        n_vec++; if (t >= 40) begin n_err++; $display("FAIL tank2_revive_timeout: got no pulse expected pulse within 40 cycles"); end
        repeat (6) @(negedge clk);
        n_vec++; if (lleft[11:8] !== 4'd0 || die[2] !== 1'b0) begin n_err++; $display("FAIL tank2_alive_last_life: got lives=%0d die=%b expected 0 0", lleft[11:8], die[2]); end
        box = 4'b0100; bullet = 4'b0010;
        @(negedge clk);
        clear_inputs();
        repeat (15) @(negedge clk);
        n_vec++; if (eout !== 1'b0 || die[2] !== 1'b1) begin n_err++; $display("FAIL tank2_dead_eout: got eout=%b die2=%b expected 0 1", eout, die[2]); end
        @(negedge clk);
        n_vec++; if (eout !== 1'b0) begin n_err++; $display("FAIL eout_latency: got %b expected 0", eout); end
        @(negedge clk);
        n_vec++; if (eout !== 1'b1 || pout !== 1'b0) begin n_err++; $display("FAIL eout_assert: got eout=%b pout=%b expected 1 0", eout, pout); end
    endtask

    task automatic test_load_mid_dead();
        int rc;
        rc = 0;
        box = 4'b0001; bullet = 4'b0100;
        @(negedge clk);
        clear_inputs();
        n_vec++; if (die[0] !== 1'b1) begin n_err++; $display("FAIL mid_dead_die: got %b expected 1", die[0]); end
        repeat (3) @(negedge clk);
        lives = 16'h1233; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n_vec++; if (die !== 4'b0 || lleft !== 16'h0122) begin n_err++; $display("FAIL reload_state: got die=%b lives=%h expected 0000 0122", die, lleft); end
        for (int i = 0; i < 12; i++) begin
            if (revive != 4'b0) rc++;
            @(negedge clk);
        end
        n_vec++; if (rc != 0) begin n_err++; $display("FAIL reload_no_revive: got %0d pulses expected 0", rc); end
        n_vec++; if (eout !== 1'b0) begin n_err++; $display("FAIL reload_eout: got %b expected 0", eout); end
    endtask

    task automatic test_reset_mid_dead();
        box = 4'b0010; bullet = 4'b1000;
        @(negedge clk);
        clear_inputs();
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_vec++; if (die !== 4'b0 || revive !== 4'b0 || lleft !== 16'h0 || eout !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got die=%b rev=%b lives=%h eout=%b expected all 0", die, revive, lleft, eout);
        end
        @(negedge clk);
        reset = 1'b0;
        box = 4'b0001; bullet = 4'b0100;
        @(negedge clk);
        clear_inputs();
        n_vec++; if (die !== 4'b0) begin n_err++; $display("FAIL idle_ignores_hit: got %b expected 0000", die); end
    endtask

    task automatic test_zero_lives();
        do_load(16'h0011);
        n_vec++; if (die !== 4'b1100 || lleft !== 16'h0) begin n_err++; $display("FAIL zero_lives_load: got die=%b lives=%h expected 1100 0000", die, lleft); end
        n_vec++; if (eout !== 1'b0) begin n_err++; $display("FAIL zero_lives_eout_early: got %b expected 0", eout); end
        @(negedge clk);
        n_vec++; if (eout !== 1'b1 || pout !== 1'b0) begin n_err++; $display("FAIL zero_lives_eout: got eout=%b pout=%b expected 1 0", eout, pout); end
    endtask

`ifdef SPAWN_SHIELD_EN
    task automatic test_shield();
        int t;
        do_load(16'h3333);
        box = 4'b0001; bullet = 4'b0100;
        @(negedge clk);
        clear_inputs();
        t = 0;
        while (!revive[0] && t < 30) begin @(negedge clk); t++; end
        n_vec++; if (t >= 30) begin n_err++; $display("FAIL shield_revive_timeout: got no pulse expected pulse within 30 cycles"); end
        n_vec++; if (shield[0] !== 1'b1) begin n_err++; $display("FAIL shield_active: got %b expected 1", shield[0]); end
        for (int c = 1; c <= 4; c++) begin
            box = 4'b0001; bullet = 4'b0100;
            @(negedge clk);
        end
        clear_inputs();
        n_vec++; if (die[0] !== 1'b0 || shield[0] !== 1'b0) begin n_err++; $display("FAIL shield_window: got die=%b shield=%b expected 0 0", die[0], shield[0]); end
        box = 4'b0001; bullet = 4'b0100;
        @(negedge clk);
        clear_inputs();
        n_vec++; if (die[0] !== 1'b1) begin n_err++; $display("FAIL shield_expired_kill: got %b expected 1", die[0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_hit_revive();
        test_friendly();
        test_enemy_out();
        test_load_mid_dead();
        test_reset_mid_dead();
        test_zero_lives();
`ifdef SPAWN_SHIELD_EN
        test_shield();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
